vote_session_scheduler: RTL and testbench
=========================================

VOTE_SESSION_SCHEDULER -- requirements
Module: vote_session_scheduler

Interface
REQ-001 Parameter N_BOOTH, default 4, number of booth stations sharing the vote counter.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles a granted booth may take to choose.
REQ-003 Parameter MAX_BALLOTS, default 100, ballot count that automatically closes the session.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 open  input  1  level; starts a session from IDLE.
REQ-007 close  input  1  level; requests session end.
REQ-008 req  input  N_BOOTH  per-booth vote request, level.
REQ-009 sel  input  2*N_BOOTH  booth i choice at sel[2i+1:2i]: 00 none, 01 A, 10 B, 11 C.
REQ-010 tie_in  input  1  counter reports a tie (winner code 11).
REQ-011 key_val  output  4  unlock key to the counter.
REQ-012 a_n, b_n, c_n  output  1 each  active-low one-cycle vote strobes to the counter.
REQ-013 vote_done  output  1  one-cycle pulse ending the vote phase.
REQ-014 grant  output  N_BOOTH  one-hot grant to the booth currently voting.
REQ-015 ballots  output  7  ballots cast this round.
REQ-016 timeouts  output  7  grants expired without a choice, this session.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 States: IDLE, ARM, WAIT_REQ, GRANT, CAST, RELEASE, DONE.
REQ-019 IDLE: all outputs inactive; open=1 -> ARM.
REQ-020 ARM: key_val=4'hF for exactly one cycle, else key_val=0; clear ballots and timeouts; -> WAIT_REQ.
REQ-021 WAIT_REQ: close=1 or ballots==MAX_BALLOTS -> DONE (close has priority over req); else any req bit -> GRANT; else stay.
REQ-022 Arbitration: round-robin; search starts at the booth after the last granted (booth 0 first after reset/ARM); the selected booth's grant bit is set on entry to GRANT.
REQ-023 GRANT: grant held; a 10-bit window counter starts at 0 and increments each cycle.
REQ-024 GRANT: granted booth sel != 00 -> CAST latching the choice; req withdrawn -> RELEASE with no vote; counter reaches TIMEOUT-1 with sel==00 -> RELEASE, timeouts+1 (saturating at 127).
REQ-025 CAST: exactly one of a_n/b_n/c_n low for one cycle per latched choice; ballots+1 (saturating at 127); -> RELEASE.
REQ-026 RELEASE: grant=0 for one cycle; -> WAIT_REQ. The same booth cannot vote twice in a row while others are requesting.
REQ-027 close during GRANT/CAST does not abort the current ballot; it is honoured in WAIT_REQ.
REQ-028 DONE: vote_done=1 for exactly the first cycle; next cycle tie_in=1 -> WAIT_REQ with ballots cleared (runoff, no new ARM); tie_in=0 -> IDLE.
REQ-029 Strobes are mutually exclusive and never asserted outside CAST; a_n/b_n/c_n idle high.
REQ-030 Vote-to-strobe latency: choice seen in GRANT cycle n produces a strobe in cycle n+1.
REQ-031 Unused sel/req bits of non-granted booths are ignored while a grant is held.

Reset
REQ-032 rst asserted in any state: state=IDLE, key_val=0, a_n=b_n=c_n=1, vote_done=0, grant=0, ballots=0, timeouts=0, busy=0, round-robin pointer to booth N_BOOTH-1 (so booth 0 is searched first).
REQ-033 rst mid-GRANT or mid-CAST discards the ballot: no strobe is emitted after rst rises.

Verification
REQ-034 open pulse, req=0001, sel[1:0]=10 -> key_val=F for one cycle, grant=0001, b_n low once, ballots=1.
REQ-035 req=1111 held, all sel=01 -> grants in order 0001,0010,0100,1000,0001 with one RELEASE cycle between each grant.
REQ-036 req=0100, sel=00 for the full window -> grant held 15 cycles, no strobe, timeouts=1.
REQ-037 close raised during CAST -> strobe still issued, then DONE, vote_done pulses once, back to IDLE.
REQ-038 DONE with tie_in=1 -> WAIT_REQ, ballots=0, no key_val pulse; next vote counted normally.
REQ-039 MAX_BALLOTS=3, continuous requests -> after the third strobe enters DONE without close.

Source files
------------

// File: rtl/vote_session_scheduler.sv
// vote_session_scheduler
// ----------------------
// Schedules access of N_BOOTH booth stations to a shared vote counter.
// A session is opened from IDLE, the counter is unlocked with a one-cycle
// key, and booths are then granted one at a time in round-robin order.
// A granted booth has TIMEOUT cycles to make a choice. The choice becomes
// a one-cycle active-low strobe (A, B or C) to the counter. The session
// ends on close or after MAX_BALLOTS ballots. A tie reported by the counter
// starts a runoff round without re-arming.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   open_i       level, starts a session from IDLE
//   close_i      level, requests session end (honoured between ballots)
//   req_i        per-booth vote request, level
//   sel_i        booth i choice at [2i+1:2i]: 00 none, 01 A, 10 B, 11 C
//   tie_in_i     counter reports a tie, sampled at the end of DONE
//   key_val_o    unlock key, 4'hF for the single ARM cycle
//   a_n_o/b_n_o/c_n_o  active-low one-cycle vote strobes
//   vote_done_o  one-cycle pulse on entry to DONE
//   grant_o      one-hot grant to the booth currently voting
//   ballots_o    ballots cast this round (saturating)
//   timeouts_o   grants expired without a choice this session (saturating)
//   busy_o       high whenever the scheduler is not IDLE
module vote_session_scheduler #(
  parameter int N_BOOTH     = 4,
  parameter int TIMEOUT     = 15,
  parameter int MAX_BALLOTS = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   open_i,
  input  logic                   close_i,
  input  logic [N_BOOTH-1:0]     req_i,
  input  logic [2*N_BOOTH-1:0]   sel_i,
  input  logic                   tie_in_i,
  output logic [3:0]             key_val_o,
  output logic                   a_n_o,
  output logic                   b_n_o,
  output logic                   c_n_o,
  output logic                   vote_done_o,
  output logic [N_BOOTH-1:0]     grant_o,
  output logic [6:0]             ballots_o,
  output logic [6:0]             timeouts_o,
  output logic                   busy_o
);

  localparam int IDX_W = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1;
  localparam logic [IDX_W-1:0] LAST_BOOTH = IDX_W'(N_BOOTH - 1);
  localparam logic [9:0]       WIN_LAST   = 10'(TIMEOUT - 1);
  localparam logic [6:0]       BALLOT_CAP = 7'(MAX_BALLOTS);
  localparam logic [6:0]       SAT_MAX    = 7'h7F;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_REQ,
    GRANT,
    CAST,
    RELEASE,
    DONE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   last_q;
  logic [9:0]         win_q;
  logic [3:0]         key_val_q;
  logic               a_n_q, b_n_q, c_n_q;
  logic               vote_done_q;
  logic [N_BOOTH-1:0] grant_q;
  logic [6:0]         ballots_q;
  logic [6:0]         timeouts_q;
  logic               busy_q;

  logic [IDX_W-1:0]   pick_d;
  logic               found_d;
  logic [IDX_W-1:0]   idx_d;
  logic [1:0]         gsel_d;
  logic               greq_d;

  // Round-robin search: start one past the last granted booth and wrap, so
  // the booth that just voted is considered last.
  always_comb begin
    pick_d  = last_q;
    found_d = 1'b0;
    idx_d   = last_q;
    for (int k = 1; k <= N_BOOTH; k++) begin
      idx_d = IDX_W'((int'(last_q) + k) % N_BOOTH);
      if (!found_d && req_i[idx_d]) begin
        pick_d  = idx_d;
        found_d = 1'b1;
      end
    end
  end

  // Only the granted booth's request and choice are looked at; last_q holds
  // the granted booth for the whole GRANT/CAST period.
  assign gsel_d = sel_i[{last_q, 1'b0} +: 2];
  assign greq_d = req_i[last_q];

  // Main scheduler FSM with registered outputs. Pulse-type outputs (key,
  // strobes, vote_done) default to inactive every cycle and are only set on
  // the transition into the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= LAST_BOOTH;
      win_q       <= '0;
      key_val_q   <= '0;
      a_n_q       <= 1'b1;
      b_n_q       <= 1'b1;
      c_n_q       <= 1'b1;
      vote_done_q <= 1'b0;
      grant_q     <= '0;
      ballots_q   <= '0;
      timeouts_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      key_val_q   <= '0;
      a_n_q       <= 1'b1;
      b_n_q       <= 1'b1;
      c_n_q       <= 1'b1;
      vote_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (open_i) begin
            state_q    <= ARM;
            key_val_q  <= 4'hF;
            busy_q     <= 1'b1;
            ballots_q  <= '0;
            timeouts_q <= '0;
            last_q     <= LAST_BOOTH;
          end
        end
        ARM: begin
          state_q <= WAIT_REQ;
        end
        WAIT_REQ: begin
          if (close_i || ballots_q == BALLOT_CAP) begin
            state_q     <= DONE;
            vote_done_q <= 1'b1;
          end else if (found_d) begin
            state_q <= GRANT;
            grant_q <= N_BOOTH'(1) << pick_d;
            last_q  <= pick_d;
            win_q   <= '0;
          end
        end
        GRANT: begin
          // The strobe registers themselves latch the choice for CAST.
          if (gsel_d != 2'b00) begin
            state_q <= CAST;
            a_n_q   <= (gsel_d != 2'b01);
            b_n_q   <= (gsel_d != 2'b10);
            c_n_q   <= (gsel_d != 2'b11);
          end else if (!greq_d) begin
            state_q <= RELEASE;
            grant_q <= '0;
          end else if (win_q == WIN_LAST) begin
            state_q <= RELEASE;
            grant_q <= '0;
            if (timeouts_q != SAT_MAX) timeouts_q <= timeouts_q + 7'd1;
          end else begin
            win_q <= win_q + 10'd1;
          end
        end
        CAST: begin
          state_q <= RELEASE;
          grant_q <= '0;
          if (ballots_q != SAT_MAX) ballots_q <= ballots_q + 7'd1;
        end
        RELEASE: begin
          state_q <= WAIT_REQ;
        end
        DONE: begin
          // First DONE cycle carries vote_done; the tie decision is taken
          // in the following cycle.
          if (!vote_done_q) begin
            if (tie_in_i) begin
              state_q   <= WAIT_REQ;
              ballots_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign key_val_o   = key_val_q;
  assign a_n_o       = a_n_q;
  assign b_n_o       = b_n_q;
  assign c_n_o       = c_n_q;
  assign vote_done_o = vote_done_q;
  assign grant_o     = grant_q;
  assign ballots_o   = ballots_q;
  assign timeouts_o  = timeouts_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_vote_session_scheduler.sv
// tb_vote_session_scheduler
// -------------------------
// Directed bench for vote_session_scheduler. Expected strobe codes are
// pushed to a queue when a booth's choice is driven and popped by a
// monitor when the DUT strobes. A second instance with MAX_BALLOTS=3
// shares the inputs and is observed only in the auto-close scenario.
module tb_vote_session_scheduler;

  logic       clk;
  logic       rst;
  logic       openSig, closeSig, tieSig;
  logic [3:0] reqSig;
  logic [7:0] selSig;

  logic [3:0] keyVal;
  logic       aN, bN, cN, voteDone, busy;
  logic [3:0] grant;
  logic [6:0] ballots, timeouts;

  logic [3:0] keyVal3;
  logic       aN3, bN3, cN3, voteDone3, busy3;
  logic [3:0] grant3;
  logic [6:0] ballots3, timeouts3;

  int testCount = 0;
  int failCount = 0;
  int keyCycles = 0;
  int doneCycles = 0;
  bit scoreOn = 1'b1;
  logic [1:0] expQ[$];
  logic [1:0] monGot;
  int monLows;

  vote_session_scheduler #(.N_BOOTH(4), .TIMEOUT(15), .MAX_BALLOTS(100)) dut (
    .clk(clk), .rst(rst), .open_i(openSig), .close_i(closeSig),
    .req_i(reqSig), .sel_i(selSig), .tie_in_i(tieSig),
    .key_val_o(keyVal), .a_n_o(aN), .b_n_o(bN), .c_n_o(cN),
    .vote_done_o(voteDone), .grant_o(grant), .ballots_o(ballots),
    .timeouts_o(timeouts), .busy_o(busy)
  );

  vote_session_scheduler #(.N_BOOTH(4), .TIMEOUT(15), .MAX_BALLOTS(3)) dut3 (
    .clk(clk), .rst(rst), .open_i(openSig), .close_i(closeSig),
    .req_i(reqSig), .sel_i(selSig), .tie_in_i(tieSig),
    .key_val_o(keyVal3), .a_n_o(aN3), .b_n_o(bN3), .c_n_o(cN3),
    .vote_done_o(voteDone3), .grant_o(grant3), .ballots_o(ballots3),
    .timeouts_o(timeouts3), .busy_o(busy3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and on mismatch count and report the failure.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive every DUT input in one go.
  task automatic applyStimulus(input logic o, input logic c, input logic [3:0] r,
                               input logic [7:0] s, input logic t);
    openSig  = o;
    closeSig = c;
    reqSig   = r;
    selSig   = s;
    tieSig   = t;
  endtask

  // Strobe levels {a_n,b_n,c_n} the counter must see for a choice code.
  function automatic logic [2:0] strobePattern(input logic [1:0] code);
    case (code)
      2'b01:   return 3'b011;
      2'b10:   return 3'b101;
      2'b11:   return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  // Wait (bounded) for a particular grant pattern, then compare it.
  task automatic waitGrant(input string tag, input logic [3:0] expGrant);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant !== expGrant && n < 40);
    checkOutput(tag, 16'(grant), 16'(expGrant));
  endtask

  // Wait (bounded) for the scheduler to fall back to IDLE.
  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 16'(busy), 16'(1'b0));
  endtask

  // One complete ballot from a single booth: request, grant, strobe, release.
  task automatic voteOnce(input int booth, input logic [1:0] code);
    logic [3:0] r;
    logic [7:0] s;
    r = 4'b0001 << booth;
    s = 8'(code) << (2 * booth);
    applyStimulus(1'b0, 1'b0, r, s, 1'b0);
    waitGrant($sformatf("voteGrant%0d", booth), r);
    expQ.push_back(code);
    @(negedge clk);
    checkOutput("castStrobe", 16'({aN, bN, cN}), 16'(strobePattern(code)));
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    @(negedge clk);
    checkOutput("releaseGrant", 16'(grant), 16'(4'b0));
  endtask

  // Pulse open for one cycle.
  task automatic openSession();
    openSig = 1'b1;
    @(negedge clk);
    openSig = 1'b0;
  endtask

  // Monitor on the falling edge: count key and vote_done cycles, and check
  // every strobe of the main DUT against the scoreboard.
  always @(negedge clk) begin
    if (keyVal == 4'hF) keyCycles++;
    if (voteDone) doneCycles++;
    if (scoreOn && (!aN || !bN || !cN)) begin
      monLows = 0;
      if (!aN) monLows++;
      if (!bN) monLows++;
      if (!cN) monLows++;
      checkOutput("strobeExclusive", 16'(monLows), 16'd1);
      checkOutput("strobeDuringGrant", 16'(grant != 4'b0), 16'd1);
      monGot = !aN ? 2'b01 : (!bN ? 2'b10 : 2'b11);
      if (expQ.size() == 0) checkOutput("strobeUnexpected", 16'(monGot), 16'd0);
      else checkOutput("strobeCode", 16'(monGot), 16'(expQ.pop_front()));
    end
  end

  // Directed scenario sequence.
  initial begin
    int hold;
    int keyBefore;
    int doneBefore;
    int n;
    int strobes3;
    bit seenDone;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstKey", 16'(keyVal), 16'h0);
    checkOutput("rstStrobes", 16'({aN, bN, cN}), 16'(3'b111));
    checkOutput("rstDone", 16'(voteDone), 16'h0);
    checkOutput("rstGrant", 16'(grant), 16'h0);
    checkOutput("rstBallots", 16'(ballots), 16'h0);
    checkOutput("rstTimeouts", 16'(timeouts), 16'h0);
    checkOutput("rstBusy", 16'(busy), 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single vote for B from booth 0, then close the session.
    $display("[TB] single vote");
    openSession();
    voteOnce(0, 2'b10);
    checkOutput("keyPulse", 16'(keyCycles), 16'd1);
    checkOutput("singleBallots", 16'(ballots), 16'd1);
    doneBefore = doneCycles;
    applyStimulus(1'b0, 1'b1, 4'b0, 8'b0, 1'b0);
    waitIdle("singleIdle");
    checkOutput("singleDonePulse", 16'(doneCycles - doneBefore), 16'd1);
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    @(negedge clk);

    // All booths requesting: grants rotate 0,1,2,3,0 with a gap between.
    $display("[TB] round robin");
    openSession();
    applyStimulus(1'b0, 1'b0, 4'hF, 8'h55, 1'b0);
    for (int i = 0; i < 5; i++) begin
      waitGrant($sformatf("rrGrant%0d", i), 4'b0001 << (i % 4));
      expQ.push_back(2'b01);
      @(negedge clk);
      checkOutput("rrStrobe", 16'({aN, bN, cN}), 16'(3'b011));
      if (i == 4) applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("rrGap%0d", i), 16'(grant), 16'h0);
    end
    checkOutput("rrBallots", 16'(ballots), 16'd5);

    // Booth 2 never chooses: grant held for the full window, then expires.
    $display("[TB] timeout");
    applyStimulus(1'b0, 1'b0, 4'b0100, 8'b0, 1'b0);
    waitGrant("toGrant", 4'b0100);
    hold = 1;
    n = 0;
    while (grant === 4'b0100 && n < 40) begin
      @(negedge clk);
      n++;
      if (grant === 4'b0100) hold++;
    end
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    checkOutput("toHold", 16'(hold), 16'd15);
    checkOutput("toTimeouts", 16'(timeouts), 16'd1);
    checkOutput("toBallots", 16'(ballots), 16'd5);

    // Booth 3 withdraws its request: released with no vote and no timeout.
    $display("[TB] withdraw");
    applyStimulus(1'b0, 1'b0, 4'b1000, 8'b0, 1'b0);
    waitGrant("wdGrant", 4'b1000);
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    @(negedge clk);
    checkOutput("wdRelease", 16'(grant), 16'h0);
    checkOutput("wdTimeouts", 16'(timeouts), 16'd1);

    // Close raised while the ballot is being cast: strobe still issued.
    $display("[TB] close during cast");
    applyStimulus(1'b0, 1'b0, 4'b0001, 8'b0000_0011, 1'b0);
    waitGrant("closeGrant", 4'b0001);
    expQ.push_back(2'b11);
    applyStimulus(1'b0, 1'b1, 4'b0001, 8'b0000_0011, 1'b0);
    @(negedge clk);
    checkOutput("closeStrobe", 16'({aN, bN, cN}), 16'(3'b110));
    doneBefore = doneCycles;
    applyStimulus(1'b0, 1'b1, 4'b0, 8'b0, 1'b0);
    waitIdle("closeIdle");
    checkOutput("closeDonePulse", 16'(doneCycles - doneBefore), 16'd1);
    checkOutput("closeBallots", 16'(ballots), 16'd6);
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    @(negedge clk);

    // Tie reported in DONE: runoff back to WAIT_REQ without a new key.
    $display("[TB] tie runoff");
    openSession();
    voteOnce(1, 2'b01);
    keyBefore = keyCycles;
    doneBefore = doneCycles;
    applyStimulus(1'b0, 1'b1, 4'b0, 8'b0, 1'b1);
    n = 0;
    while (voteDone !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("tieBusy", 16'(busy), 16'd1);
    checkOutput("tieBallots", 16'(ballots), 16'd0);
    checkOutput("tieNoKey", 16'(keyCycles - keyBefore), 16'd0);
    checkOutput("tieDonePulse", 16'(doneCycles - doneBefore), 16'd1);
    voteOnce(2, 2'b10);
    checkOutput("tieNextBallot", 16'(ballots), 16'd1);

    // Reset while a choice is pending in GRANT: the ballot is discarded.
    $display("[TB] reset mid grant");
    applyStimulus(1'b0, 1'b0, 4'b1000, 8'b0, 1'b0);
    waitGrant("rstMidGrant", 4'b1000);
    applyStimulus(1'b0, 1'b0, 4'b1000, 8'b0100_0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstMidStrobes", 16'({aN, bN, cN}), 16'(3'b111));
    checkOutput("rstMidGrant0", 16'(grant), 16'h0);
    checkOutput("rstMidBusy", 16'(busy), 16'h0);
    checkOutput("rstMidBallots", 16'(ballots), 16'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    @(negedge clk);

    // MAX_BALLOTS=3 instance: continuous requests close the session alone.
    $display("[TB] auto close");
    scoreOn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    openSession();
    applyStimulus(1'b0, 1'b0, 4'hF, 8'h55, 1'b0);
    n = 0;
    strobes3 = 0;
    seenDone = 1'b0;
    while (!seenDone && n < 200) begin
      @(negedge clk);
      n++;
      if (!aN3 || !bN3 || !cN3) strobes3++;
      if (voteDone3) seenDone = 1'b1;
    end
    checkOutput("maxDone", 16'(seenDone), 16'd1);
    checkOutput("maxStrobes", 16'(strobes3), 16'd3);
    checkOutput("maxBallots", 16'(ballots3), 16'd3);
    applyStimulus(1'b0, 1'b0, 4'b0, 8'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("maxIdle", 16'(busy3), 16'd0);

    checkOutput("queueEmpty", 16'(expQ.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
